// File: rtl/uart_rx_if.sv
// Stream bundle between uart_rx and its downstream byte consumer:
// a one-entry data/valid/ready stream plus the receiver's status pulses.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames from rxd into a one-entry stream with error pulses.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master strm
);

    localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity   = 3'd3;
`endif
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitIdle = 3'd5;

    logic        rxd_meta_q;
    logic        rxd_s_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        cnt_zero;
    logic        byte_done;
    logic        stop_bad;
    logic        par_fail;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        parity_err_q;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
`endif

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    assign cnt_zero = (cnt_q == 16'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        par_fail  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rxd_s_q) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = FULL_RELOAD;
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    cnt_d   = FULL_RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    par_bad_d = (rxd_s_q != ^shift_q);
                    cnt_d     = FULL_RELOAD;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s_q) begin
                    state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                    // Parity is reported only once the stop bit is known good,
                    // so a doubly-bad frame shows up as a framing error alone.
                    par_fail  = par_bad_q;
                    byte_done = !par_bad_q;
`else
                    byte_done = 1'b1;
`endif
                end else begin
                    stop_bad = 1'b1;
                    state_d  = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (rxd_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // One-entry output buffer; a byte arriving while the buffer is stuck is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= stop_bad;
            parity_err_q <= par_fail;
            overrun_q    <= byte_done && valid_q && !strm.ready;
            if (byte_done && (!valid_q || strm.ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && strm.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign strm.data      = data_q;
    assign strm.valid     = valid_q;
    assign strm.frame_err = frame_err_q;
    assign strm.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign strm.parity_err = parity_err_q;
`else
    assign strm.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level event model plus literal pins.
module tb_uart_rx;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Start edge driven on rxd to the stop-bit sample edge: sync + detect, half bit, rest of frame.
    localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB;

    localparam int KBYTE = 0;
    localparam int KFERR = 1;
    localparam int KPERR = 2;

    localparam int SVALID = 0;
    localparam int SDATA  = 1;
    localparam int SFERR  = 2;
    localparam int SOVR   = 3;
    localparam int SPERR  = 4;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } pin_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    bit   started = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    ev_t  evq[$];
    pin_t pinq[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_perr = 1'b0;

    uart_rx_if strm ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .strm (strm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] sig_val(input int s);
        case (s)
            SVALID:  return {7'd0, strm.valid};
            SDATA:   return strm.data;
            SFERR:   return {7'd0, strm.frame_err};
            SOVR:    return {7'd0, strm.overrun};
            default: return {7'd0, strm.parity_err};
        endcase
    endfunction

    // Frame-level model: each completed frame lands at its stop-sample edge.
    always @(posedge clk) begin
        ev_t ev;
        bit  got;
        cyc = cyc + 1;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
        got    = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            if (evq.size() != 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.kind == KFERR) m_ferr = 1'b1;
                else if (ev.kind == KPERR) m_perr = 1'b1;
                else got = 1'b1;
            end
            if (got) begin
                if (!m_valid || strm.ready) begin
                    m_valid = 1'b1;
                    m_data  = ev.data;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && strm.ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        pin_t keep[$];
        if (started) begin
            if (rst) begin
                check("rst_valid", {31'd0, strm.valid}, 32'd0);
                check("rst_data", {24'd0, strm.data}, 32'd0);
                check("rst_frame_err", {31'd0, strm.frame_err}, 32'd0);
                check("rst_overrun", {31'd0, strm.overrun}, 32'd0);
                check("rst_parity_err", {31'd0, strm.parity_err}, 32'd0);
            end else begin
                check("valid", {31'd0, strm.valid}, {31'd0, m_valid});
                if (m_valid) check("data", {24'd0, strm.data}, {24'd0, m_data});
                check("frame_err", {31'd0, strm.frame_err}, {31'd0, m_ferr});
                check("overrun", {31'd0, strm.overrun}, {31'd0, m_ovr});
                check("parity_err", {31'd0, strm.parity_err}, {31'd0, m_perr});
            end
            keep = {};
            foreach (pinq[i]) begin
                if (pinq[i].cyc == cyc) begin
                    check(pinq[i].name, {24'd0, sig_val(pinq[i].sig)}, {24'd0, pinq[i].val});
                end else begin
                    keep.push_back(pinq[i]);
                end
            end
            pinq = keep;
        end
    end

    task automatic pin(input int at, input int s, input logic [7:0] v, input string name);
        pin_t p;
        p.cyc  = at;
        p.sig  = s;
        p.val  = v;
        p.name = name;
        pinq.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        idle(CPB);
    endtask

    // Drives one frame starting now (1 time unit after an edge); optionally predicts its outcome.
    task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                        input bit expect_ev);
        ev_t ev;
        if (expect_ev) begin
            ev.cyc  = cyc + LAT;
            ev.data = d;
            ev.kind = KBYTE;
            if (!stop_bit) ev.kind = KFERR;
`ifdef UART_RX_PARITY_EN
            else if (par_bit != ^d) ev.kind = KPERR;
`endif
            evq.push_back(ev);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit === 1'bx) rxd = 1'b1;
`endif
        drive_bit(stop_bit);
    endtask

    initial begin
        int k;
        strm.ready = 1'b1;
        #1 rst = 1'b1;
        #1 started = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        rst = 1'b0;
        idle(10);

        // Reset mid-bench with the line idle, then a clean 0xA5.
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(4);
        k = cyc;
        pin(k + LAT - 1, SVALID, 8'h00, "a5_valid_before");
        pin(k + LAT, SVALID, 8'h01, "a5_valid");
        pin(k + LAT, SDATA, 8'hA5, "a5_data");
        pin(k + LAT + 1, SVALID, 8'h00, "a5_valid_one_cycle");
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(6);

        // Two-cycle glitch: must be rejected as a false start.
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(20);

        // Bad stop bit, then a 40-cycle break, then 0x01.
        k = cyc;
        pin(k + LAT, SFERR, 8'h01, "ferr_pulse");
        pin(k + LAT + 1, SFERR, 8'h00, "ferr_one_cycle");
        send(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(40);
        rxd = 1'b1;
        idle(12);
        k = cyc;
        pin(k + LAT, SDATA, 8'h01, "after_break_data");
        send(8'h01, 1'b1, 1'b0, 1'b1);
        idle(5);

        // Stalled consumer: 0x11 held, 0x22 dropped with one overrun.
        strm.ready = 1'b0;
        send(8'h11, 1'b1, 1'b0, 1'b1);
        k = cyc;
        pin(k + LAT, SOVR, 8'h01, "overrun_pulse");
        pin(k + LAT, SDATA, 8'h11, "overrun_keeps_old");
        send(8'h22, 1'b1, 1'b0, 1'b1);
        idle(5);
        pin(cyc + 1, SVALID, 8'h00, "drain_valid_drop");
        strm.ready = 1'b1;
        idle(5);

        // Ready rises in the very cycle 0x7E completes: replace, no overrun.
        strm.ready = 1'b0;
        send(8'h55, 1'b1, 1'b0, 1'b1);
        idle(3);
        k = cyc;
        pin(k + LAT, SOVR, 8'h00, "swap_no_overrun");
        pin(k + LAT, SDATA, 8'h7E, "swap_data");
        pin(k + LAT + 1, SVALID, 8'h00, "swap_consumed");
        fork
            send(8'h7E, 1'b1, 1'b0, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 strm.ready = 1'b1;
            end
        join
        idle(5);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even weight so its even-parity bit is 0.
        k = cyc;
        pin(k + LAT, SPERR, 8'h01, "perr_pulse");
        pin(k + LAT, SVALID, 8'h00, "perr_no_valid");
        send(8'h03, 1'b1, 1'b1, 1'b1);
        k = cyc;
        pin(k + LAT, SDATA, 8'h03, "par_ok_data");
        send(8'h03, 1'b1, 1'b0, 1'b1);
        k = cyc;
        pin(k + LAT, SFERR, 8'h01, "both_bad_ferr");
        pin(k + LAT, SPERR, 8'h00, "both_bad_no_perr");
        send(8'h03, 1'b0, 1'b1, 1'b1);
        rxd = 1'b1;
        idle(5);
`endif

        // Reset in the middle of a frame: nothing may come out of it.
        fork
            send(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                idle(30);
                rst = 1'b1;
                idle(3);
                rst = 1'b0;
            end
        join
        idle(10);
        k = cyc;
        pin(k + LAT, SDATA, 8'h5A, "post_reset_data");
        send(8'h5A, 1'b1, 1'b0, 1'b1);
        idle(10);

        check("pins_pending", pinq.size(), 32'd0);
        check("events_pending", evq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
